// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the AXI-Stream deadlock monitor.
// Channel codes: bit0 = local stall, bit1 = stall seen through the sub-instance.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_LOCAL = 2'b01;
  localparam logic [1:0] CODE_SUB   = 2'b10;
  localparam logic [1:0] CODE_BOTH  = 2'b11;

  // All-ones marker for "no channel"; callers truncate to their index width.
  function automatic logic [31:0] NO_CH();
    return '1;
  endfunction

  function automatic logic [1:0] chan_code(input logic local_stall, input logic sub_stall);
    logic [1:0] code;
    unique case ({sub_stall, local_stall})
      2'b01:   code = CODE_LOCAL;
      2'b10:   code = CODE_SUB;
      2'b11:   code = CODE_BOTH;
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/deadlock_persist_filter.sv
// Persistence filter: a stall must be seen THRESHOLD consecutive cycles before
// it is reported. enter_o strobes on the edge that moves the FSM into BLOCKED.
module deadlock_persist_filter
  import deadlock_mon_pkg::*;
#(
  parameter int THRESHOLD = 1,
  parameter bit STICKY    = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  input  logic clear_i,
  output logic enter_o,
  output logic in_blocked_o
);

  localparam int CW = $clog2(THRESHOLD + 1);

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic          at_limit;

  // count_q is held at 0 in IDLE, so THRESHOLD==1 also reaches the limit from IDLE.
  assign at_limit     = (int'(count_q) == THRESHOLD - 1);
  assign enter_o      = !clear_i && raw_i && at_limit && (state_q != BLOCKED);
  assign in_blocked_o = (state_q == BLOCKED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (raw_i && at_limit) begin
            state_q <= BLOCKED;
            count_q <= '0;
          end else if (raw_i) begin
            state_q <= SUSPECT;
            count_q <= CW'(1);
          end
        end
        SUSPECT: begin
          if (!raw_i) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (at_limit) begin
            state_q <= BLOCKED;
            count_q <= '0;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        BLOCKED: begin
          if (!STICKY && !raw_i) begin
            state_q <= IDLE;
            count_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_deadlock_monitor.sv
// Deadlock monitor top: derives the stall indication, runs it through the
// persistence filter and latches a per-channel diagnostic snapshot on entry.
module axis_deadlock_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int NUM_INST  = 2,
  parameter int THRESHOLD = 1,
  parameter int CNT_W     = 16,
  parameter bit STICKY    = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [2*NUM_CH-1:0]        axis_block_sigs,
  input  logic                       sub_block,
  input  logic [NUM_INST-1:0]        inst_idle_sigs,
  input  logic                       clear,
  output logic                       block,
  output logic [2*NUM_CH-1:0]        axis_block_info,
  output logic [$clog2(NUM_CH):0]    first_ch,
  output logic [CNT_W-1:0]           block_cycles
);

  localparam int CH_W = $clog2(NUM_CH) + 1;
  localparam logic [CH_W-1:0] NoCh = CH_W'(NO_CH());

  logic [NUM_CH-1:0]   cur;
  logic [NUM_CH-1:0]   sub;
  logic                raw;
  logic [2*NUM_CH-1:0] codes;
  logic [CH_W-1:0]     lowest;
  logic                enter;
  logic                in_blocked;

  logic [2*NUM_CH-1:0] info_q;
  logic [CH_W-1:0]     first_q;
  logic [CNT_W-1:0]    cycles_q;

  assign cur = axis_block_sigs[NUM_CH-1:0];
  assign sub = axis_block_sigs[2*NUM_CH-1:NUM_CH];
  // A system whose instances all report idle is quiescent, not deadlocked.
  assign raw = !(&inst_idle_sigs) && ((|cur) || (sub_block && (|sub)));

  always_comb begin
    codes  = '0;
    lowest = NoCh;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      codes[2*i +: 2] = chan_code(cur[i], sub[i] & sub_block);
      if (codes[2*i +: 2] != CODE_NONE) begin
        lowest = CH_W'(i);
      end
    end
  end

  deadlock_persist_filter #(
    .THRESHOLD (THRESHOLD),
    .STICKY    (STICKY)
  ) u_filter (
    .clock        (clock),
    .reset_n      (reset_n),
    .raw_i        (raw),
    .clear_i      (clear),
    .enter_o      (enter),
    .in_blocked_o (in_blocked)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      info_q   <= '0;
      first_q  <= NoCh;
      cycles_q <= '0;
    end else if (enter) begin
      info_q   <= codes;
      first_q  <= lowest;
      cycles_q <= CNT_W'(1);
    end else if (in_blocked && (cycles_q != {CNT_W{1'b1}})) begin
      cycles_q <= cycles_q + CNT_W'(1);
    end
  end

  // Snapshot registers are only meaningful while BLOCKED; masking with the
  // state flop restores reset values on the exit edge without a next-state path.
  assign block           = in_blocked;
  assign axis_block_info = in_blocked ? info_q : '0;
  assign first_ch        = in_blocked ? first_q : NoCh;
  assign block_cycles    = in_blocked ? cycles_q : '0;

endmodule

// File: tb/tb_axis_deadlock_monitor.sv
// Scoreboard bench: two monitors (immediate/non-sticky and THRESHOLD=4/sticky)
// share one stimulus stream and are checked against a run-length reference model.
module tb_axis_deadlock_monitor;

  typedef struct {
    int         due;
    logic       blk0;
    logic       blk1;
    logic [3:0] info0;
    logic [3:0] info1;
    logic [1:0] first0;
    logic [1:0] first1;
    int         cyc0;
    int         cyc1;
  } expect_t;

  logic        clock;
  logic        reset_n;
  logic [3:0]  axisBlockSigs;
  logic        subBlock;
  logic [1:0]  instIdleSigs;
  logic        clearIn;

  logic        fastBlock;
  logic [3:0]  fastInfo;
  logic [1:0]  fastFirst;
  logic [15:0] fastCycles;
  logic        stickyBlock;
  logic [3:0]  stickyInfo;
  logic [1:0]  stickyFirst;
  logic [3:0]  stickyCycles;

  int checks;
  int errors;
  int cycleCount;
  expect_t scoreQ[$];

  int   thr[2]  = '{1, 4};
  bit   stk[2]  = '{1'b0, 1'b1};
  int   cmax[2] = '{65535, 15};
  bit   mBlk[2];
  int   mRun[2];
  logic [3:0] mSnap[2];
  logic [1:0] mFirst[2];
  int   mCyc[2];

  axis_deadlock_monitor #(
    .NUM_CH(2), .NUM_INST(2), .THRESHOLD(1), .CNT_W(16), .STICKY(1'b0)
  ) dutFast (
    .clock           (clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axisBlockSigs),
    .sub_block       (subBlock),
    .inst_idle_sigs  (instIdleSigs),
    .clear           (clearIn),
    .block           (fastBlock),
    .axis_block_info (fastInfo),
    .first_ch        (fastFirst),
    .block_cycles    (fastCycles)
  );

  axis_deadlock_monitor #(
    .NUM_CH(2), .NUM_INST(2), .THRESHOLD(4), .CNT_W(4), .STICKY(1'b1)
  ) dutSticky (
    .clock           (clock),
    .reset_n         (reset_n),
    .axis_block_sigs (axisBlockSigs),
    .sub_block       (subBlock),
    .inst_idle_sigs  (instIdleSigs),
    .clear           (clearIn),
    .block           (stickyBlock),
    .axis_block_info (stickyInfo),
    .first_ch        (stickyFirst),
    .block_cycles    (stickyCycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mBlk[k] = 1'b0;
      mRun[k] = 0;
      mSnap[k] = 4'b0000;
      mFirst[k] = 2'b11;
      mCyc[k] = 0;
    end
  endtask

  // Reference: count consecutive stalled cycles; report once the run reaches the threshold.
  task automatic modelStep(input int k, input logic [1:0] cur, input logic [1:0] sub,
                           input logic sb, input logic [1:0] idle, input logic clr);
    logic       raw;
    logic [3:0] codes;
    logic [1:0] lowest;
    raw    = (idle != 2'b11) && ((cur != 2'b00) || (sb && (sub != 2'b00)));
    codes  = 4'b0000;
    lowest = 2'b11;
    for (int i = 1; i >= 0; i--) begin
      codes[2*i]   = cur[i];
      codes[2*i+1] = sub[i] & sb;
      if (cur[i] || (sub[i] && sb)) lowest = 2'(i);
    end
    if (clr) begin
      mBlk[k] = 1'b0;
      mRun[k] = 0;
    end else if (!mBlk[k]) begin
      if (raw) begin
        mRun[k]++;
        if (mRun[k] >= thr[k]) begin
          mBlk[k]   = 1'b1;
          mRun[k]   = 0;
          mSnap[k]  = codes;
          mFirst[k] = lowest;
          mCyc[k]   = 1;
        end
      end else begin
        mRun[k] = 0;
      end
    end else begin
      if (!stk[k] && !raw) begin
        mBlk[k] = 1'b0;
        mRun[k] = 0;
      end else if (mCyc[k] < cmax[k]) begin
        mCyc[k]++;
      end
    end
  endtask

  task automatic pushExpected(input int due);
    expect_t e;
    e.due    = due;
    e.blk0   = mBlk[0];
    e.blk1   = mBlk[1];
    e.info0  = mBlk[0] ? mSnap[0] : 4'b0000;
    e.info1  = mBlk[1] ? mSnap[1] : 4'b0000;
    e.first0 = mBlk[0] ? mFirst[0] : 2'b11;
    e.first1 = mBlk[1] ? mFirst[1] : 2'b11;
    e.cyc0   = mBlk[0] ? mCyc[0] : 0;
    e.cyc1   = mBlk[1] ? mCyc[1] : 0;
    scoreQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] cur, input logic [1:0] sub, input logic sb,
                               input logic [1:0] idle, input logic clr);
    @(negedge clock);
    axisBlockSigs = {sub, cur};
    subBlock      = sb;
    instIdleSigs  = idle;
    clearIn       = clr;
    modelStep(0, cur, sub, sb, idle, clr);
    modelStep(1, cur, sub, sb, idle, clr);
    pushExpected(cycleCount + 1);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleCount, actual, expected);
    end
  endtask

  // Monitor: compare every due expectation half a cycle after the edge that produced it.
  initial begin
    expect_t e;
    forever begin
      @(negedge clock or negedge reset_n);
      #1;
      while (scoreQ.size() > 0 && scoreQ[0].due <= cycleCount) begin
        e = scoreQ.pop_front();
        checkOutput("fast.block",         int'(fastBlock),    int'(e.blk0));
        checkOutput("fast.info",          int'(fastInfo),     int'(e.info0));
        checkOutput("fast.first_ch",      int'(fastFirst),    int'(e.first0));
        checkOutput("fast.block_cycles",  int'(fastCycles),   e.cyc0);
        checkOutput("sticky.block",       int'(stickyBlock),  int'(e.blk1));
        checkOutput("sticky.info",        int'(stickyInfo),   int'(e.info1));
        checkOutput("sticky.first_ch",    int'(stickyFirst),  int'(e.first1));
        checkOutput("sticky.block_cycles", int'(stickyCycles), e.cyc1);
      end
    end
  end

  initial begin
    logic [1:0] c;
    logic [1:0] s;
    logic       b;
    logic [1:0] idl;
    int         hold;

    checks = 0;
    errors = 0;
    cycleCount = 0;
    reset_n = 1'b0;
    axisBlockSigs = 4'b0000;
    subBlock = 1'b0;
    instIdleSigs = 2'b00;
    clearIn = 1'b0;
    modelReset();
    pushExpected(0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Local stall on channel 0, then release.
    repeat (3) applyStimulus(2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    repeat (2) applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

    // Burst of 3, one-cycle gap, burst of 4.
    repeat (3) applyStimulus(2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    repeat (4) applyStimulus(2'b10, 2'b00, 1'b0, 2'b00, 1'b0);
    repeat (3) applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b1);

    // Sub-instance stall, ignored until sub_block qualifies it.
    repeat (3) applyStimulus(2'b00, 2'b10, 1'b0, 2'b00, 1'b0);
    repeat (5) applyStimulus(2'b00, 2'b10, 1'b1, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b1);

    // Long stall: sticky counter saturates, report holds after release until clear.
    repeat (20) applyStimulus(2'b11, 2'b01, 1'b1, 2'b01, 1'b0);
    repeat (3) applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b1);
    repeat (2) applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

    // All instances idle masks the stall; clear on the entry edge wins.
    repeat (5) applyStimulus(2'b11, 2'b00, 1'b0, 2'b11, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 2'b00, 1'b1);
    repeat (2) applyStimulus(2'b01, 2'b00, 1'b0, 2'b00, 1'b0);

    // Asynchronous reset while both monitors are blocked, then re-detection.
    repeat (6) applyStimulus(2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    axisBlockSigs = 4'b0000;
    subBlock = 1'b0;
    clearIn = 1'b0;
    modelReset();
    pushExpected(cycleCount);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) applyStimulus(2'b01, 2'b00, 1'b0, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 2'b00, 1'b1);

    // Randomized patterns held for a few cycles each so thresholds are reachable.
    for (int n = 0; n < 80; n++) begin
      c    = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      s    = 2'($urandom_range(0, 3));
      b    = 1'($urandom_range(0, 1));
      idl  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        applyStimulus(c, s, b, idl, ($urandom_range(0, 24) == 0));
      end
    end

    repeat (3) @(negedge clock);
    #2;
    checks++;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", scoreQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
